usb_rx_ctrl: RTL and testbench
==============================

// Module: usb_rx_ctrl
// PURPOSE
//  USB full-speed receive-side packet controller, the counterpart of the transmit FSM.
//  Consumes decoded bytes from the NRZI decoder / serial-to-parallel shifter.
//  Validates SYNC and PID, then streams payload bytes to the RX data FIFO.
//  Withholds the two trailing CRC bytes; reports packet type, completion and errors to the protocol layer.
// PARAMETERS
//  MAX_DATA_BYTES  64  max payload bytes in a DATA packet, CRC excluded; exceeding it is an error
// PORTS
//  clk               in   1  system clock
//  n_rst             in   1  asynchronous, active-low reset
//  d_edge            in   1  1-clk pulse: first line transition seen (packet start)
//  byte_received     in   1  1-clk pulse: rcv_data holds a complete byte
//  rcv_data          in   8  received byte; [3:0]=PID, [7:4]=~PID for the PID byte
//  eop               in   1  level: SE0 (EOP) present on bus
//  fifo_full         in   1  RX data FIFO cannot accept a write
//  rcving            out  1  high from d_edge until packet end or error resolution
//  flush             out  1  1-clk pulse at packet start; clears the RX FIFO
//  w_enable          out  1  1-clk FIFO write strobe
//  rx_data           out  8  FIFO write data, valid with w_enable
//  rx_packet         out  3  0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 BAD
//  rx_data_ready     out  1  1-clk pulse: clean DATA packet fully stored
//  rx_error          out  1  level; set on any error, cleared at next d_edge
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, holdback regs and counters cleared.
//   Reset mid-packet abandons the packet; nothing is written after reset.
//  States: IDLE, SYNC_WAIT, PID_WAIT, TOKEN, DATA, HS_EOP, EOP_WAIT, DONE, ERR_WAIT.
//  IDLE -d_edge-> SYNC_WAIT: flush=1 for 1 clk, rcving=1, rx_error<=0, rx_packet<=0.
//  SYNC_WAIT: on byte_received, rcv_data==8'h80 -> PID_WAIT; otherwise -> ERR_WAIT.
//  PID_WAIT: on byte_received, check that [7:4]!=~[3:0] or the PID is unknown -> rx_packet=7 and ERR_WAIT.
//   PID encodings: OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010.
//   Routing: token -> TOKEN; DATA0/1 -> DATA; ACK/NAK -> HS_EOP.
//   rx_packet is updated on the clk after byte_received and held until the next d_edge.
//  TOKEN: counts bytes; eop with exactly 2 bytes -> EOP_WAIT; any other count -> ERR_WAIT.
//  HS_EOP: eop -> EOP_WAIT; byte_received -> ERR_WAIT.
//  DATA: 2-entry holdback (hb0 newest, hb1 oldest) plus valid count 0..2.
//   On byte_received with count==2: w_enable=1 and rx_data=hb1 on the next clk, then shift.
//   Net effect: each payload byte is written 2 bytes late, and the 2 CRC bytes are never written.
//   A write attempted while fifo_full=1, or a payload count > MAX_DATA_BYTES -> ERR_WAIT, no write.
//   eop with holdback count<2 -> ERR_WAIT. eop with count==2 -> EOP_WAIT.
//  EOP_WAIT: wait for eop deassert -> DONE.
//  DONE: rcving<=0; rx_data_ready=1 for 1 clk if the packet was DATA and clean; -> IDLE.
//  ERR_WAIT: rx_error=1; no writes; wait for eop deassert after eop has been seen; then rcving<=0 -> IDLE.
//  Simultaneous events:
//   byte_received and eop in the same clk = EOP mid-byte -> ERR_WAIT.
//   d_edge outside IDLE is ignored.
//  Payload counter is 7 bits and saturates. A DATA packet with 0 payload bytes (CRC only) is legal.
// CONFIGURATION
//  USB_RX_CRC16_CHECK_EN defined:
//   CRC16 (poly 0x8005, init 0xFFFF) is accumulated over every DATA-packet byte after the PID, CRC included.
//   At eop in DATA, a residual != 16'h800D -> ERR_WAIT, rx_error=1, no rx_data_ready.
//   Payload bytes already written remain in the FIFO; the consumer must discard them on rx_error.
//  Not defined: no CRC logic is instantiated; the CRC bytes are dropped unchecked.
// STRUCTURE
//  usb_pkg: rx_packet_t enum (values above), PID 4-bit localparams, SYNC_BYTE=8'h80, CRC16 poly/init/residual.
//  State enum is local to this module.
//  Sub-module usb_crc16_chk (byte-wide CRC16 update with clear/enable), instantiated only under USB_RX_CRC16_CHECK_EN.
// TESTING
//  ACK: 80,D2,eop -> rx_packet=5, no w_enable, rx_error=0, rcving falls after eop release.
//  DATA0 80,C3,11,22,33,<crc>,eop -> exactly 3 writes 11,22,33; rx_data_ready pulse; rx_packet=3.
//  Bad PID 80,C4 -> rx_packet=7, rx_error=1, zero writes, IDLE after eop.
//  Bad SYNC 81 -> rx_error=1; next clean ACK clears rx_error at its d_edge.
//  fifo_full=1 during 3rd payload write -> rx_error=1, that byte not written, no rx_data_ready.
//  (CRC_EN) corrupted CRC byte -> rx_error=1, no rx_data_ready; n_rst mid-DATA -> all outputs 0 immediately.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB receive definitions: packet type codes, PID encodings, SYNC byte and
// the CRC16 constants plus a byte-wide CRC16 update helper.
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_IN    = 3'd2,
        PKT_DATA0 = 3'd3,
        PKT_DATA1 = 3'd4,
        PKT_ACK   = 3'd5,
        PKT_NAK   = 3'd6,
        PKT_BAD   = 3'd7
    } rx_packet_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [7:0]  SYNC_BYTE      = 8'h80;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // A PID byte is only trusted when its upper nibble is the complement of the lower one.
    function automatic rx_packet_t decode_pid(input logic [7:0] pid_byte);
        if (pid_byte[7:4] != ~pid_byte[3:0]) begin
            return PKT_BAD;
        end
        case (pid_byte[3:0])
            PID_OUT:   return PKT_OUT;
            PID_IN:    return PKT_IN;
            PID_DATA0: return PKT_DATA0;
            PID_DATA1: return PKT_DATA1;
            PID_ACK:   return PKT_ACK;
            PID_NAK:   return PKT_NAK;
            default:   return PKT_BAD;
        endcase
    endfunction

    // Bits enter LSB first, matching the order they arrived on the wire.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[15]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16_chk.sv
// Byte-wide CRC16 accumulator; residual_ok is high once the data plus its own CRC
// have been folded in without corruption.
module usb_crc16_chk
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic       residual_ok
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = crc16_byte(crc_q, data_in);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign residual_ok = (crc_q == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive packet controller: checks SYNC/PID, streams DATA payload to the
// RX FIFO while holding back the CRC bytes. Define USB_RX_CRC16_CHECK_EN to verify CRC16.
module usb_rx_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic       eop,
    input  logic       fifo_full,
    output logic       rcving,
    output logic       flush,
    output logic       w_enable,
    output logic [7:0] rx_data,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_error
);

    typedef enum logic [3:0] {
        IDLE, SYNC_WAIT, PID_WAIT, TOKEN, DATA, HS_EOP, EOP_WAIT, DONE, ERR_WAIT
    } state_t;

    state_t     state_q, state_d;
    rx_packet_t rx_packet_q, rx_packet_d, pid_pkt;
    logic       rcving_q, rcving_d, flush_q, flush_d, w_enable_q, w_enable_d;
    logic       rx_data_ready_q, rx_data_ready_d, rx_error_q, rx_error_d;
    logic       eop_seen_q, eop_seen_d, err_req, crc_ok;
    logic [7:0] rx_data_q, rx_data_d, hb0_q, hb0_d, hb1_q, hb1_d;
    logic [1:0] hb_cnt_q, hb_cnt_d, tok_cnt_q, tok_cnt_d;
    logic [6:0] pay_cnt_q, pay_cnt_d;

`ifdef USB_RX_CRC16_CHECK_EN
    logic crc_clear, crc_enable;
    assign crc_clear  = (state_q == IDLE) && d_edge;
    assign crc_enable = (state_q == DATA) && byte_received && !eop;

    usb_crc16_chk u_crc16_chk (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (crc_clear),
        .enable      (crc_enable),
        .data_in     (rcv_data),
        .residual_ok (crc_ok)
    );
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        rx_packet_d     = rx_packet_q;
        rcving_d        = rcving_q;
        flush_d         = 1'b0;
        w_enable_d      = 1'b0;
        rx_data_d       = rx_data_q;
        rx_data_ready_d = 1'b0;
        rx_error_d      = rx_error_q;
        eop_seen_d      = eop_seen_q;
        hb0_d           = hb0_q;
        hb1_d           = hb1_q;
        hb_cnt_d        = hb_cnt_q;
        tok_cnt_d       = tok_cnt_q;
        pay_cnt_d       = pay_cnt_q;
        err_req         = 1'b0;
        pid_pkt         = decode_pid(rcv_data);

        case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d     = SYNC_WAIT;
                    flush_d     = 1'b1;
                    rcving_d    = 1'b1;
                    rx_error_d  = 1'b0;
                    rx_packet_d = PKT_NONE;
                    eop_seen_d  = 1'b0;
                    hb_cnt_d    = 2'd0;
                    tok_cnt_d   = 2'd0;
                    pay_cnt_d   = 7'd0;
                end
            end
            SYNC_WAIT: begin
                if (eop || (byte_received && rcv_data != SYNC_BYTE)) begin
                    err_req = 1'b1;
                end else if (byte_received) begin
                    state_d = PID_WAIT;
                end
            end
            PID_WAIT: begin
                if (eop) begin
                    err_req = 1'b1;
                end else if (byte_received) begin
                    rx_packet_d = pid_pkt;
                    case (pid_pkt)
                        PKT_OUT, PKT_IN:     state_d = TOKEN;
                        PKT_DATA0, PKT_DATA1: state_d = DATA;
                        PKT_ACK, PKT_NAK:    state_d = HS_EOP;
                        default:             err_req = 1'b1;
                    endcase
                end
            end
            TOKEN: begin
                if (eop) begin
                    if (!byte_received && tok_cnt_q == 2'd2) begin
                        state_d = EOP_WAIT;
                    end else begin
                        err_req = 1'b1;
                    end
                end else if (byte_received && tok_cnt_q != 2'd3) begin
                    tok_cnt_d = tok_cnt_q + 2'd1;
                end
            end
            HS_EOP: begin
                if (byte_received) begin
                    err_req = 1'b1;
                end else if (eop) begin
                    state_d = EOP_WAIT;
                end
            end
            DATA: begin
                if (eop) begin
                    if (!byte_received && hb_cnt_q == 2'd2 && crc_ok) begin
                        state_d = EOP_WAIT;
                    end else begin
                        err_req = 1'b1;
                    end
                end else if (byte_received) begin
                    // The oldest held byte is payload only once two newer bytes are behind it.
                    if (hb_cnt_q == 2'd2) begin
                        if (fifo_full || pay_cnt_q >= 7'(MAX_DATA_BYTES)) begin
                            err_req = 1'b1;
                        end else begin
                            w_enable_d = 1'b1;
                            rx_data_d  = hb1_q;
                            hb1_d      = hb0_q;
                            hb0_d      = rcv_data;
                            if (pay_cnt_q != 7'h7F) begin
                                pay_cnt_d = pay_cnt_q + 7'd1;
                            end
                        end
                    end else begin
                        hb1_d    = hb0_q;
                        hb0_d    = rcv_data;
                        hb_cnt_d = hb_cnt_q + 2'd1;
                    end
                end
            end
            EOP_WAIT: begin
                if (!eop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rcving_d        = 1'b0;
                rx_data_ready_d = (rx_packet_q == PKT_DATA0) || (rx_packet_q == PKT_DATA1);
                state_d         = IDLE;
            end
            ERR_WAIT: begin
                eop_seen_d = eop_seen_q | eop;
                if (eop_seen_q && !eop) begin
                    rcving_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_req) begin
            state_d    = ERR_WAIT;
            rx_error_d = 1'b1;
            eop_seen_d = eop;
            w_enable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            rx_packet_q     <= PKT_NONE;
            rcving_q        <= 1'b0;
            flush_q         <= 1'b0;
            w_enable_q      <= 1'b0;
            rx_data_q       <= 8'd0;
            rx_data_ready_q <= 1'b0;
            rx_error_q      <= 1'b0;
            eop_seen_q      <= 1'b0;
            hb0_q           <= 8'd0;
            hb1_q           <= 8'd0;
            hb_cnt_q        <= 2'd0;
            tok_cnt_q       <= 2'd0;
            pay_cnt_q       <= 7'd0;
        end else begin
            state_q         <= state_d;
            rx_packet_q     <= rx_packet_d;
            rcving_q        <= rcving_d;
            flush_q         <= flush_d;
            w_enable_q      <= w_enable_d;
            rx_data_q       <= rx_data_d;
            rx_data_ready_q <= rx_data_ready_d;
            rx_error_q      <= rx_error_d;
            eop_seen_q      <= eop_seen_d;
            hb0_q           <= hb0_d;
            hb1_q           <= hb1_d;
            hb_cnt_q        <= hb_cnt_d;
            tok_cnt_q       <= tok_cnt_d;
            pay_cnt_q       <= pay_cnt_d;
        end
    end

    assign rcving        = rcving_q;
    assign flush         = flush_q;
    assign w_enable      = w_enable_q;
    assign rx_data       = rx_data_q;
    assign rx_packet     = rx_packet_q;
    assign rx_data_ready = rx_data_ready_q;
    assign rx_error      = rx_error_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed self-checking bench for usb_rx_ctrl: handshake, token and DATA packets,
// malformed packets, FIFO back-pressure, payload limit and reset mid-packet.
module tb_usb_rx_ctrl;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       eop = 1'b0;
    logic       fifo_full = 1'b0;
    logic       rcving, flush, w_enable, rx_data_ready, rx_error;
    logic [7:0] rx_data;
    logic [2:0] rx_packet;

    int errors = 0;
    int checks = 0;

    logic [7:0] wr_log[$];
    int ready_cnt = 0;
    int flush_cnt = 0;

    usb_rx_ctrl #(.MAX_DATA_BYTES(64)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .eop           (eop),
        .fifo_full     (fifo_full),
        .rcving        (rcving),
        .flush         (flush),
        .w_enable      (w_enable),
        .rx_data       (rx_data),
        .rx_packet     (rx_packet),
        .rx_data_ready (rx_data_ready),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    // Record every FIFO write and status pulse so each test can look at its own slice.
    always @(negedge clk) begin
        if (w_enable) wr_log.push_back(rx_data);
        if (rx_data_ready) ready_cnt++;
        if (flush) flush_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_data = b;
        byte_received = 1'b1;
        step(1);
        byte_received = 1'b0;
        step(2);
    endtask

    task automatic send_eop();
        eop = 1'b1;
        step(2);
        eop = 1'b0;
        step(3);
    endtask

    task automatic send_packet(input byte_q_t bytes);
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        step(1);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    // Appends the two CRC16 bytes exactly as a USB transmitter would put them on the wire.
    function automatic byte_q_t with_crc(input byte_q_t p);
        logic [15:0] c;
        logic [15:0] r;
        logic [7:0]  b0, b1;
        byte_q_t     q;
        c = 16'hFFFF;
        q = p;
        foreach (p[i]) begin
            for (int k = 0; k < 8; k++) begin
                if (p[i][k] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
                else c = {c[14:0], 1'b0};
            end
        end
        r = ~c;
        for (int k = 0; k < 8; k++) begin
            b0[k] = r[15 - k];
            b1[k] = r[7 - k];
        end
        q.push_back(b0);
        q.push_back(b1);
        return q;
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        step(2);
        checks++;
        if ({rcving, flush, w_enable, rx_data_ready, rx_error} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {rcving, flush, w_enable, rx_data_ready, rx_error});
        end
        checks++;
        if ({rx_data, rx_packet} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: rx_data=%h rx_packet=%0d expected 0/0", rx_data, rx_packet);
        end
        n_rst = 1'b1;
        step(2);
    endtask

    task automatic test_ack();
        int wb = wr_log.size();
        int rb = ready_cnt;
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        checks++;
        if ({flush, rcving} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL ack_start: flush,rcving=%b expected 11", {flush, rcving});
        end
        step(1);
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_flush_pulse: flush=%b expected 0", flush);
        end
        send_byte(8'h80);
        send_byte(8'hD2);
        checks++;
        if (rx_packet !== 3'd5 || rcving !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_pid: rx_packet=%0d rcving=%b expected 5/1", rx_packet, rcving);
        end
        send_eop();
        checks++;
        if (rcving !== 1'b0 || rx_error !== 1'b0 || rx_packet !== 3'd5) begin
            errors++;
            $display("[TB] FAIL ack_end: rcving=%b rx_error=%b rx_packet=%0d expected 0/0/5", rcving, rx_error, rx_packet);
        end
        checks++;
        if (wr_log.size() - wb != 0 || ready_cnt - rb != 0) begin
            errors++;
            $display("[TB] FAIL ack_no_write: writes=%0d ready=%0d expected 0/0", wr_log.size() - wb, ready_cnt - rb);
        end
    endtask

    task automatic test_data0();
        int wb = wr_log.size();
        int rb = ready_cnt;
        byte_q_t p;
        p = {8'h80, 8'hC3};
        p = {p, with_crc({8'h11, 8'h22, 8'h33})};
        send_packet(p);
        send_eop();
        checks++;
        if (wr_log.size() - wb != 3) begin
            errors++;
            $display("[TB] FAIL data0_count: writes=%0d expected 3", wr_log.size() - wb);
        end else begin
            checks++;
            if ({wr_log[wb], wr_log[wb + 1], wr_log[wb + 2]} !== 24'h112233) begin
                errors++;
                $display("[TB] FAIL data0_bytes: got %h%h%h expected 112233", wr_log[wb], wr_log[wb + 1], wr_log[wb + 2]);
            end
        end
        checks++;
        if (ready_cnt - rb != 1 || rx_packet !== 3'd3 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL data0_status: ready=%0d rx_packet=%0d rx_error=%b expected 1/3/0", ready_cnt - rb, rx_packet, rx_error);
        end
    endtask

    task automatic test_bad_pid();
        int wb = wr_log.size();
        send_packet({8'h80, 8'hC4});
        checks++;
        if (rx_packet !== 3'd7 || rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_pid: rx_packet=%0d rx_error=%b expected 7/1", rx_packet, rx_error);
        end
        send_eop();
        checks++;
        if (rcving !== 1'b0 || wr_log.size() - wb != 0) begin
            errors++;
            $display("[TB] FAIL bad_pid_end: rcving=%b writes=%0d expected 0/0", rcving, wr_log.size() - wb);
        end
    endtask

    task automatic test_bad_sync();
        send_packet({8'h81});
        checks++;
        if (rx_error !== 1'b1 || rx_packet !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bad_sync: rx_error=%b rx_packet=%0d expected 1/0", rx_error, rx_packet);
        end
        send_eop();
        checks++;
        if (rx_error !== 1'b1 || rcving !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_sync_hold: rx_error=%b rcving=%b expected 1/0", rx_error, rcving);
        end
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        checks++;
        if (rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_sync_clear: rx_error=%b expected 0", rx_error);
        end
        step(1);
        send_byte(8'h80);
        send_byte(8'hD2);
        send_eop();
        checks++;
        if (rx_packet !== 3'd5 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_sync_next_ack: rx_packet=%0d rx_error=%b expected 5/0", rx_packet, rx_error);
        end
    endtask

    task automatic test_fifo_full();
        int wb = wr_log.size();
        int rb = ready_cnt;
        send_packet({8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44});
        fifo_full = 1'b1;
        send_byte(8'h55);
        fifo_full = 1'b0;
        checks++;
        if (rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fifo_full_err: rx_error=%b expected 1", rx_error);
        end
        send_eop();
        checks++;
        if (wr_log.size() - wb != 2 || ready_cnt - rb != 0) begin
            errors++;
            $display("[TB] FAIL fifo_full_writes: writes=%0d ready=%0d expected 2/0", wr_log.size() - wb, ready_cnt - rb);
        end else begin
            checks++;
            if ({wr_log[wb], wr_log[wb + 1]} !== 16'h1122) begin
                errors++;
                $display("[TB] FAIL fifo_full_bytes: got %h%h expected 1122", wr_log[wb], wr_log[wb + 1]);
            end
        end
    endtask

    task automatic test_tokens();
        send_packet({8'h80, 8'hE1, 8'h01, 8'h02});
        send_eop();
        checks++;
        if (rx_packet !== 3'd1 || rx_error !== 1'b0 || rcving !== 1'b0) begin
            errors++;
            $display("[TB] FAIL token_out: rx_packet=%0d rx_error=%b rcving=%b expected 1/0/0", rx_packet, rx_error, rcving);
        end
        send_packet({8'h80, 8'h69, 8'h05});
        send_eop();
        checks++;
        if (rx_packet !== 3'd2 || rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL token_short: rx_packet=%0d rx_error=%b expected 2/1", rx_packet, rx_error);
        end
        send_packet({8'h80, 8'hE1, 8'h01, 8'h02, 8'h03});
        send_eop();
        checks++;
        if (rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL token_long: rx_error=%b expected 1", rx_error);
        end
    endtask

    task automatic test_handshake_extra();
        send_packet({8'h80, 8'h5A});
        checks++;
        if (rx_packet !== 3'd6 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nak_pid: rx_packet=%0d rx_error=%b expected 6/0", rx_packet, rx_error);
        end
        send_byte(8'h77);
        send_eop();
        checks++;
        if (rx_error !== 1'b1 || rcving !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nak_extra_byte: rx_error=%b rcving=%b expected 1/0", rx_error, rcving);
        end
    endtask

    task automatic test_data1_empty();
        int wb = wr_log.size();
        int rb = ready_cnt;
        byte_q_t p;
        byte_q_t none;
        p = {8'h80, 8'h4B};
        p = {p, with_crc(none)};
        send_packet(p);
        send_eop();
        checks++;
        if (wr_log.size() - wb != 0 || ready_cnt - rb != 1 || rx_packet !== 3'd4 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL data1_empty: writes=%0d ready=%0d rx_packet=%0d rx_error=%b expected 0/1/4/0",
                     wr_log.size() - wb, ready_cnt - rb, rx_packet, rx_error);
        end
    endtask

    task automatic test_eop_mid_byte();
        int wb = wr_log.size();
        int rb = ready_cnt;
        send_packet({8'h80, 8'hC3, 8'h11, 8'h22});
        rcv_data = 8'h33;
        byte_received = 1'b1;
        eop = 1'b1;
        step(1);
        byte_received = 1'b0;
        checks++;
        if (rx_error !== 1'b1 || w_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eop_mid_byte: rx_error=%b w_enable=%b expected 1/0", rx_error, w_enable);
        end
        step(1);
        eop = 1'b0;
        step(3);
        checks++;
        if (wr_log.size() - wb != 0 || ready_cnt - rb != 0 || rcving !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eop_mid_byte_end: writes=%0d ready=%0d rcving=%b expected 0/0/0", wr_log.size() - wb, ready_cnt - rb, rcving);
        end
    endtask

    task automatic test_d_edge_ignored();
        int wb = wr_log.size();
        int fb = flush_cnt;
        send_packet({8'h80, 8'hC3, 8'hA1, 8'hA2});
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        step(1);
        send_byte(8'hA3);
        send_byte(8'hA4);
        send_eop();
        checks++;
        if (flush_cnt - fb != 1 || wr_log.size() - wb != 2 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL d_edge_ignored: flushes=%0d writes=%0d rx_error=%b expected 1/2/0", flush_cnt - fb, wr_log.size() - wb, rx_error);
        end
    endtask

    task automatic test_max_payload();
        int wb = wr_log.size();
        int rb = ready_cnt;
        byte_q_t pay;
        byte_q_t p;
        for (int i = 0; i < 64; i++) pay.push_back(8'(i + 1));
        p = {8'h80, 8'hC3};
        p = {p, with_crc(pay)};
        send_packet(p);
        send_eop();
        checks++;
        if (wr_log.size() - wb != 64 || ready_cnt - rb != 1 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL max_payload_ok: writes=%0d ready=%0d rx_error=%b expected 64/1/0", wr_log.size() - wb, ready_cnt - rb, rx_error);
        end else begin
            checks++;
            if (wr_log[wb + 63] !== 8'h40) begin
                errors++;
                $display("[TB] FAIL max_payload_last: got %h expected 40", wr_log[wb + 63]);
            end
        end
        wb = wr_log.size();
        rb = ready_cnt;
        pay.push_back(8'h41);
        p = {8'h80, 8'h4B};
        p = {p, with_crc(pay)};
        send_packet(p);
        send_eop();
        checks++;
        if (wr_log.size() - wb != 64 || ready_cnt - rb != 0 || rx_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_payload_over: writes=%0d ready=%0d rx_error=%b expected 64/0/1", wr_log.size() - wb, ready_cnt - rb, rx_error);
        end
    endtask

`ifdef USB_RX_CRC16_CHECK_EN
    task automatic test_crc_error();
        int wb = wr_log.size();
        int rb = ready_cnt;
        byte_q_t p;
        p = {8'h80, 8'hC3};
        p = {p, with_crc({8'h11, 8'h22, 8'h33})};
        p[p.size() - 1] = p[p.size() - 1] ^ 8'h01;
        send_packet(p);
        send_eop();
        checks++;
        if (rx_error !== 1'b1 || ready_cnt - rb != 0 || wr_log.size() - wb != 3) begin
            errors++;
            $display("[TB] FAIL crc_error: rx_error=%b ready=%0d writes=%0d expected 1/0/3", rx_error, ready_cnt - rb, wr_log.size() - wb);
        end
    endtask
`endif

    task automatic test_reset_mid_data();
        int wb = wr_log.size();
        send_packet({8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44});
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({rcving, flush, w_enable, rx_data_ready, rx_error, rx_packet, rx_data} !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_data: rcving=%b rx_packet=%0d rx_data=%h expected all 0", rcving, rx_packet, rx_data);
        end
        step(1);
        n_rst = 1'b1;
        step(1);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        checks++;
        if (wr_log.size() - wb != 2 || rcving !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_write: writes=%0d rcving=%b expected 2/0", wr_log.size() - wb, rcving);
        end
        send_packet({8'h80, 8'hD2});
        send_eop();
        checks++;
        if (rx_packet !== 3'd5 || rx_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_recover: rx_packet=%0d rx_error=%b expected 5/0", rx_packet, rx_error);
        end
    endtask

    initial begin
        $display("[TB] usb_rx_ctrl directed test start");
        test_reset();
        test_ack();
        test_data0();
        test_bad_pid();
        test_bad_sync();
        test_fifo_full();
        test_tokens();
        test_handshake_extra();
        test_data1_empty();
        test_eop_mid_byte();
        test_d_edge_ignored();
        test_max_payload();
`ifdef USB_RX_CRC16_CHECK_EN
        test_crc_error();
`endif
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
